// File: rtl/character_pkg.sv
// Shared encodings for the character animation path: state/game enums and
// per-state frame counts, imported by both this controller and the sprite renderer.
package character_pkg;

  typedef enum logic [7:0] {
    CS_STAND  = 8'd0,
    CS_ATTACK = 8'd1,
    CS_MOVEL  = 8'd2,
    CS_MOVER  = 8'd3,
    CS_HURT   = 8'd4,
    CS_DEFEND = 8'd5,
    CS_DIE    = 8'd6
  } char_state_t;

  typedef enum logic [7:0] {
    GS_START = 8'd0,
    GS_GAME  = 8'd1,
    GS_OVER  = 8'd2
  } game_state_t;

  localparam logic [7:0] FRAMES_STAND  = 8'd8;
  localparam logic [7:0] FRAMES_ATTACK = 8'd9;
  localparam logic [7:0] FRAMES_MOVEL  = 8'd5;
  localparam logic [7:0] FRAMES_MOVER  = 8'd5;
  localparam logic [7:0] FRAMES_HURT   = 8'd4;
  localparam logic [7:0] FRAMES_DEFEND = 8'd1;
  localparam logic [7:0] FRAMES_DIE    = 8'd12;

  function automatic logic [7:0] frame_count(input char_state_t s);
    logic [7:0] n;
    case (s)
      CS_ATTACK: n = FRAMES_ATTACK;
      CS_MOVEL:  n = FRAMES_MOVEL;
      CS_MOVER:  n = FRAMES_MOVER;
      CS_HURT:   n = FRAMES_HURT;
      CS_DEFEND: n = FRAMES_DEFEND;
      CS_DIE:    n = FRAMES_DIE;
      default:   n = FRAMES_STAND;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings the asynchronous ~60 Hz frame strobe into Clk and emits a one-cycle
// tick on every FRAME_DIV-th synchronised rising edge; clr restarts the count.
module frame_tick_gen #(
  parameter int unsigned FRAME_DIV = 6
) (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  input  logic clr,
  output logic tick
);

  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  logic       sync1_reg;
  logic       sync2_reg;
  logic       prev_reg;
  logic [7:0] div_reg;
  logic       rise;

  assign rise = sync2_reg & ~prev_reg;
  assign tick = rise && (div_reg == DIV_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
      div_reg   <= 8'd0;
    end else begin
      sync1_reg <= frame_clk;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
      // A clear on the same cycle as an edge drops that edge.
      if (clr)
        div_reg <= 8'd0;
      else if (rise)
        div_reg <= (div_reg == DIV_LAST) ? 8'd0 : div_reg + 8'd1;
    end
  end

endmodule

// File: rtl/character_anim_ctrl.sv
// Character animation state machine: arbitrates keys, hurt edges and HP-out into
// one state plus a paced frame index for the sprite renderer. Outputs are registered.
module character_anim_ctrl
  import character_pkg::*;
#(
  parameter int unsigned FRAME_DIV        = 6,
  parameter int unsigned ATTACK_HIT_FRAME = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] game_state,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_attack,
  input  logic       key_defend,
  input  logic       hurt_in,
  input  logic       hp_zero,
  output logic [7:0] character1_state,
  output logic [7:0] frame_num,
  output logic       move_l1,
  output logic       move_r1,
  output logic       hurt,
  output logic       character1_hurt,
  output logic       die1,
  output logic       attack_hit,
  output logic       blocked
);

  localparam logic [7:0] HIT_FRAME = 8'(ATTACK_HIT_FRAME);

  // Input capture stage
  logic [7:0] game_state_reg;
  logic       key_left_reg, key_right_reg, key_attack_reg, key_defend_reg;
  logic       hurt_in_reg, hurt_prev_reg, hp_zero_reg;

  char_state_t state_reg, state_next, target;
  logic [7:0]  frame_reg, frame_next, last_frame;
  logic        restart;
  logic        chp_reg, chp_next;
  logic        hit_reg, hit_next;
  logic        blk_reg, blk_next;
  logic        move_l_reg, move_r_reg, hurt_reg, die_reg;
  logic        hurt_rise, div_clr, tick;

  frame_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .clr       (div_clr),
    .tick      (tick)
  );

  assign hurt_rise  = hurt_in_reg & ~hurt_prev_reg;
  assign last_frame = frame_count(state_reg) - 8'd1;

  always_comb begin
    state_next = state_reg;
    frame_next = frame_reg;
    target     = state_reg;
    restart    = 1'b0;
    chp_next   = 1'b0;
    hit_next   = 1'b0;
    blk_next   = 1'b0;
    div_clr    = 1'b0;
    if (game_state_reg != GS_GAME) begin
      state_next = CS_STAND;
      frame_next = 8'd0;
      div_clr    = 1'b1;
    end else begin
      if (hp_zero_reg)
        target = CS_DIE;
      else if (hurt_rise && state_reg != CS_DIE && state_reg != CS_DEFEND) begin
        target   = CS_HURT;
        restart  = 1'b1;
        chp_next = 1'b1;
      end else if (hurt_rise && state_reg == CS_DEFEND)
        blk_next = 1'b1;
      else if (state_reg inside {CS_ATTACK, CS_HURT, CS_DIE})
        target = state_reg;
      else if (key_attack_reg)
        target = CS_ATTACK;
      else if (key_defend_reg)
        target = CS_DEFEND;
      else if (key_left_reg ^ key_right_reg)
        target = key_left_reg ? CS_MOVEL : CS_MOVER;
      else
        target = CS_STAND;

      // A state change always beats a coincident tick.
      if (restart || target != state_reg) begin
        state_next = target;
        frame_next = 8'd0;
        div_clr    = 1'b1;
      end else if (tick) begin
        if (frame_reg >= last_frame) begin
          case (state_reg)
            CS_ATTACK, CS_HURT: begin
              state_next = CS_STAND;
              frame_next = 8'd0;
              div_clr    = 1'b1;
            end
            CS_DIE:  frame_next = last_frame;
            default: frame_next = 8'd0;
          endcase
        end else begin
          frame_next = frame_reg + 8'd1;
        end
      end

      hit_next = (state_next == CS_ATTACK) && (frame_next == HIT_FRAME) &&
                 ((state_reg != CS_ATTACK) || (frame_reg != frame_next));
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      game_state_reg <= 8'd0;
      key_left_reg   <= 1'b0;
      key_right_reg  <= 1'b0;
      key_attack_reg <= 1'b0;
      key_defend_reg <= 1'b0;
      hurt_in_reg    <= 1'b0;
      hurt_prev_reg  <= 1'b0;
      hp_zero_reg    <= 1'b0;
      state_reg      <= CS_STAND;
      frame_reg      <= 8'd0;
      chp_reg        <= 1'b0;
      hit_reg        <= 1'b0;
      blk_reg        <= 1'b0;
      move_l_reg     <= 1'b0;
      move_r_reg     <= 1'b0;
      hurt_reg       <= 1'b0;
      die_reg        <= 1'b0;
    end else begin
      game_state_reg <= game_state;
      key_left_reg   <= key_left;
      key_right_reg  <= key_right;
      key_attack_reg <= key_attack;
      key_defend_reg <= key_defend;
      hurt_in_reg    <= hurt_in;
      hurt_prev_reg  <= hurt_in_reg;
      hp_zero_reg    <= hp_zero;
      state_reg      <= state_next;
      frame_reg      <= frame_next;
      chp_reg        <= chp_next;
      hit_reg        <= hit_next;
      blk_reg        <= blk_next;
      move_l_reg     <= (state_next == CS_MOVEL);
      move_r_reg     <= (state_next == CS_MOVER);
      hurt_reg       <= (state_next == CS_HURT);
      die_reg        <= (state_next == CS_DIE);
    end
  end

  assign character1_state = state_reg;
  assign frame_num        = frame_reg;
  assign move_l1          = move_l_reg;
  assign move_r1          = move_r_reg;
  assign hurt             = hurt_reg;
  assign character1_hurt  = chp_reg;
  assign die1             = die_reg;
  assign attack_hit       = hit_reg;
  assign blocked          = blk_reg;

endmodule

// File: tb/tb_character_anim_ctrl.sv
// Scoreboard bench: stimulus pushes expected output snapshots; a monitor pops one
// each time the DUT's registered outputs change and compares.
module tb_character_anim_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic [7:0] game_state = 8'd1;
  logic       key_left = 1'b0, key_right = 1'b0, key_attack = 1'b0, key_defend = 1'b0;
  logic       hurt_in = 1'b0, hp_zero = 1'b0;
  logic [7:0] character1_state, frame_num;
  logic       move_l1, move_r1, hurt, character1_hurt, die1, attack_hit, blocked;

  typedef struct packed {
    logic [7:0] st;
    logic [7:0] fr;
    logic       ml, mr, hu, ch, di, hit, blk;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    mon_en = 1'b0;

  localparam logic [7:0] ST = 8'd0, AT = 8'd1, ML = 8'd2, MR = 8'd3, HU = 8'd4, DF = 8'd5, DI = 8'd6;

  character_anim_ctrl #(.FRAME_DIV(2), .ATTACK_HIT_FRAME(4)) dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .game_state(game_state),
    .key_left(key_left), .key_right(key_right), .key_attack(key_attack),
    .key_defend(key_defend), .hurt_in(hurt_in), .hp_zero(hp_zero),
    .character1_state(character1_state), .frame_num(frame_num),
    .move_l1(move_l1), .move_r1(move_r1), .hurt(hurt),
    .character1_hurt(character1_hurt), .die1(die1), .attack_hit(attack_hit),
    .blocked(blocked)
  );

  always #10 Clk = ~Clk;

  task automatic push(input logic [7:0] st, input logic [7:0] fr,
                      input logic ch = 1'b0, input logic hit = 1'b0, input logic blk = 1'b0);
    snap_t s;
    s.st = st; s.fr = fr;
    s.ml = (st == ML); s.mr = (st == MR); s.hu = (st == HU); s.di = (st == DI);
    s.ch = ch; s.hit = hit; s.blk = blk;
    exp_q.push_back(s);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ticks(input int n);
    repeat (2 * n) begin
      @(negedge Clk); frame_clk = 1'b1;
      idle(4);
      frame_clk = 1'b0;
      idle(4);
    end
  endtask

  // Monitor: every change of the output snapshot is one transaction.
  initial begin
    snap_t cur, prev, e;
    bit first;
    first = 1'b1;
    prev = '0;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        cur = {character1_state, frame_num, move_l1, move_r1, hurt,
               character1_hurt, die1, attack_hit, blocked};
        if (first || cur !== prev) begin
          first = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got st=%0d fr=%0d flags=%b required none",
                     cur.st, cur.fr, cur[6:0]);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              failures++;
              $display("FAIL event got st=%0d fr=%0d flags=%b required st=%0d fr=%0d flags=%b",
                       cur.st, cur.fr, cur[6:0], e.st, e.fr, e[6:0]);
            end else begin
              $display("event ok t=%0t st=%0d fr=%0d flags=%b", $time, cur.st, cur.fr, cur[6:0]);
            end
          end
          prev = cur;
        end
      end
    end
  end

  initial begin
    repeat (60000) @(posedge Clk);
    failures++;
    $display("FAIL watchdog got timeout required stimulus completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    idle(3);
    push(ST, 0);
    Reset = 1'b0;
    mon_en = 1'b1;
    idle(2);

    // stand loops through 8 frames and wraps
    for (int f = 1; f < 8; f++) push(ST, 8'(f));
    push(ST, 0);
    ticks(8);

    // move right, then release
    push(MR, 0); key_right = 1'b1; idle(4);
    push(MR, 1); push(MR, 2); ticks(2);
    push(ST, 0); key_right = 1'b0; idle(4);

    // both direction keys cancel out
    push(ML, 0); key_left = 1'b1; idle(4);
    push(ST, 0); key_right = 1'b1; idle(4);
    key_left = 1'b0; key_right = 1'b0; idle(4);

    // one-shot attack, key_left ignored meanwhile
    push(AT, 0); key_attack = 1'b1; idle(1); key_attack = 1'b0; key_left = 1'b1; idle(4);
    push(AT, 1); push(AT, 2); push(AT, 3); push(AT, 4, 0, 1); push(AT, 4);
    push(AT, 5); push(AT, 6); push(AT, 7);
    ticks(7);
    key_left = 1'b0;
    push(AT, 8); push(ST, 0); ticks(2);

    // attack interrupted by hurt at frame 5
    push(AT, 0); key_attack = 1'b1; idle(1); key_attack = 1'b0; idle(4);
    push(AT, 1); push(AT, 2); push(AT, 3); push(AT, 4, 0, 1); push(AT, 4); push(AT, 5);
    ticks(5);
    push(HU, 0, 1); push(HU, 0); hurt_in = 1'b1; idle(1); hurt_in = 1'b0; idle(4);
    push(HU, 1); push(HU, 2); push(HU, 3); push(ST, 0); ticks(4);

    // held hurt level yields a single hurt
    push(HU, 0, 1); push(HU, 0); hurt_in = 1'b1; idle(100);
    push(HU, 1); push(HU, 2); push(HU, 3); push(ST, 0); ticks(4);
    hurt_in = 1'b0; idle(4);

    // defend blocks a hurt edge
    push(DF, 0); key_defend = 1'b1; idle(4);
    push(DF, 0, 0, 0, 1); push(DF, 0); hurt_in = 1'b1; idle(4);
    ticks(1);
    push(ST, 0); hurt_in = 1'b0; key_defend = 1'b0; idle(4);

    // die climbs to 11, holds, sticky after hp_zero drops
    push(DI, 0); hp_zero = 1'b1; idle(4);
    for (int f = 1; f < 12; f++) push(DI, 8'(f));
    ticks(11);
    hp_zero = 1'b0;
    ticks(20);
    push(ST, 0); game_state = 8'd2; idle(4);

    // hp_zero with a hurt edge: die, no hurt pulse; then reset mid-die
    push(DI, 0); game_state = 8'd1; hp_zero = 1'b1; hurt_in = 1'b1; idle(4);
    push(DI, 1); push(DI, 2); ticks(2);
    push(ST, 0); Reset = 1'b1; idle(3);
    Reset = 1'b0; hp_zero = 1'b0; hurt_in = 1'b0; idle(10);

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events got %0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/character_anim_ctrl.md
Name: character_anim_ctrl

Overview:
- Produces the animation state and frame index that the character sprite renderer consumes: `character1_state`, `frame_num`, move/hurt/die qualifiers.
- Arbitrates player key inputs, collision hurt events and HP-exhausted into one state machine.
- Paces frame advance from the ~60 Hz `frame_clk`.
- Sits between keyboard decode / collision logic and the sprite renderer.

Parameters:
- FRAME_DIV, 6, frame_clk rising edges per animation frame advance (1..255).
- ATTACK_HIT_FRAME, 4, attack frame index on whose entry `attack_hit` pulses.

Ports:
- Clk  in  1  50 MHz system clock.
- Reset  in  1  synchronous, active-high reset.
- frame_clk  in  1  ~60 Hz frame strobe, asynchronous to Clk (2-flop synchronised internally).
- game_state  in  8  0=start, 1=game, 2=gameover.
- key_left  in  1  left key held.
- key_right  in  1  right key held.
- key_attack  in  1  attack key held.
- key_defend  in  1  defend key held.
- hurt_in  in  1  collision hit level from opponent logic.
- hp_zero  in  1  HP exhausted (renderer's die flag).
- character1_state  out  8  0=stand, 1=attack, 2=movel, 3=mover, 4=hurt, 5=defend, 6=die.
- frame_num  out  8  current animation frame within the state.
- move_l1  out  1  state==movel.
- move_r1  out  1  state==mover.
- hurt  out  1  state==hurt.
- character1_hurt  out  1  single-cycle pulse on entry to hurt.
- die1  out  1  state==die.
- attack_hit  out  1  single-cycle pulse on entering frame ATTACK_HIT_FRAME of attack.
- blocked  out  1  single-cycle pulse when a hurt_in rising edge arrives while in defend.

Behaviour:
- Reset: state=stand, frame_num=0, divider=0, all pulses 0, sync/edge flops 0.
- All outputs are registered. An input sampled at edge N is reflected in the outputs after edge N+1.
- Frame tick: one-cycle tick on every FRAME_DIV-th synchronised rising edge of `frame_clk`.
- Frame counts per state: stand 8, attack 9, movel 5, mover 5, hurt 4, defend 1, die 12.
- Frame advance rules on tick:
  - Looping states (stand, movel, mover, defend): frame_num = (frame_num+1) mod count.
  - One-shot states (attack, hurt): advance to the last frame, then return to stand at frame 0 on the tick after the last frame.
  - die: advances to frame 11 and holds there.
- Any state change loads frame_num=0 and clears the divider in the same cycle.
- game_state != 1 (evaluated first, every cycle): force stand, frame 0, divider 0; no pulses.
- While game_state == 1, priority order (highest first):
  1. hp_zero → die. die is sticky until game_state leaves 1 or Reset.
  2. hurt_in rising edge, state not die and not defend → hurt; character1_hurt pulses. Restarts hurt at frame 0 if already in hurt.
  3. hurt_in rising edge while in defend → stay in defend; blocked pulses.
  4. In attack or hurt → continue the one-shot. Keys are ignored until it completes.
  5. key_attack from stand/movel/mover/defend → attack.
  6. key_defend → defend.
  7. key_left xor key_right → movel or mover.
  8. Otherwise → stand.
- Both direction keys held → stand.
- hurt_in is edge-detected internally: a held level causes one hurt only.
- Simultaneous hp_zero and hurt edge → die, no character1_hurt pulse.
- Simultaneous tick and state change → state change wins; frame_num=0.
- Reset mid-animation takes effect immediately on the next edge.

Decomposition:
- character_pkg holds:
  - `char_state_t` enum with encodings 0..6 as above.
  - `game_state_t` (0/1/2).
  - Per-state frame-count constants.
  - The renderer and this block both import it.
- Sub-module frame_tick_gen: frame_clk synchroniser, rising-edge detector, FRAME_DIV divider with sync clear; output `tick`.

Test Plan:
- Reset, game_state=1, no keys, FRAME_DIV=2, 16 frame_clk pulses → stand, frame_num walks 0..7 and wraps to 0 after 8 ticks.
- key_right held 3 ticks → character1_state=3 and move_r1=1 one cycle after the key; frame_num 0,1,2. Release → stand, frame 0.
- key_attack for one cycle → attack for 9 ticks; attack_hit pulses once on frame 4; key_left during the attack is ignored; then stand.
- hurt_in pulse during attack frame 5 → hurt, frame 0, character1_hurt one cycle. After 4 ticks → stand. hurt_in held high for 100 cycles → only one hurt.
- key_defend held, hurt_in rising → state stays 5, blocked pulses once, no character1_hurt.
- hp_zero=1 → die, frame_num climbs to 11 and holds through 20 more ticks. game_state 1→2 → stand, frame 0. Reset asserted mid-die → stand next edge.
